spu_boot_sequencer: RTL
=======================

Name: spu_boot_sequencer

Overview:
- Sequences the SPU's pre-run configuration: streams an image from a host into instruction memory, the register file preload port and the local-store preload port, then releases the dual-issue core from reset.
- Counts run cycles and stops the core on halt.
- Sits beside the SPU top level and drives its load_en/instruction_in, preload_* and preload_LS_* inputs plus a core reset.

Parameters:
- IMEM_DEPTH, 1024, instruction words loadable (PC range)
- RF_DEPTH, 128, registers in the register file
- LS_LINES, 2048, 128-bit local-store lines
- LS_ADDR_W, 11, local-store line address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  pulse; begins loading when in IDLE or DONE
- imem_count  in  11  instructions to load; latched at start
- rf_count  in  8  registers to preload; latched at start
- ls_count  in  12  LS lines to preload; latched at start
- in_valid  in  1  host beat valid
- in_ready  out  1  sequencer accepts beat
- in_data  in  128  host beat payload; bits [0:31] carry the instruction in IMEM phase
- halt  in  1  core halt indication, sampled in RUN
- instr_load_en  out  1  IF sequential instruction write strobe
- instr_load_data  out  32  instruction word
- preload_en  out  1  RF preload strobe
- preload_addr  out  7  RF register index
- preload_values  out  128  RF data
- preload_LS_en  out  1  LS preload strobe
- preload_LS_addr  out  LS_ADDR_W  LS line index
- preload_LS_data  out  128  LS data
- core_rst  out  1  active-low core reset; high only in RUN
- busy  out  1  high in L_IMEM, L_RF, L_LS, RELEASE
- done  out  1  high in DONE
- run_cycles  out  32  cycles spent in RUN

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; all strobes 0; all data/address outputs 0; in_ready=0; core_rst=0; busy=0; done=0; run_cycles=0; beat index=0.
- States: IDLE, L_IMEM, L_RF, L_LS, RELEASE, RUN, DONE.
- Count latching at start:
  - Counts are latched and saturated: imem to IMEM_DEPTH, rf to RF_DEPTH, ls to LS_LINES.
  - Next state is the first section with a nonzero count, in the order IMEM, RF, LS.
  - If all counts are zero, next state is RELEASE.
  - start is ignored in all states other than IDLE and DONE.
- Loading:
  - in_ready=1 in L_IMEM, L_RF and L_LS only.
  - A beat is accepted when in_valid and in_ready are both high.
  - Each accepted beat produces exactly one one-cycle strobe on the section's port in the following cycle (latency 1, registered outputs).
  - Address equals beat index, starting at 0. instr_load_data = in_data[0:31].
- Section end:
  - On acceptance of beat index count-1, the index clears.
  - The state moves to the next nonzero section, or to RELEASE; empty sections are skipped in the same transition.
  - in_valid held low simply stalls the sequencer, with no timeout.
- RELEASE:
  - Lasts exactly one cycle, so the final strobe has landed before the core leaves reset.
  - Then RUN; run_cycles clears on RELEASE entry.
- RUN:
  - core_rst=1 and run_cycles increments every cycle, saturating at 0xFFFFFFFF.
  - halt=1 moves to DONE next cycle. That cycle is counted, then the counter freezes.
- DONE:
  - core_rst=0 again; done=1; run_cycles is held.
  - start re-latches counts and reloads; done drops on leaving DONE.
- Simultaneous events: halt is ignored outside RUN. start and halt together in RUN: halt wins and start is ignored.
- Reset mid-load returns to IDLE with no partial-section resume. Strobes deassert on the reset edge.

Decomposition:
- Shared package spu_boot_pkg:
  - state enum
  - depth constants IMEM_DEPTH, RF_DEPTH, LS_LINES
  - RF address width of 7
  - instruction width of 32 and data width of 128
- One natural sub-module, boot_section_counter: a per-section beat index with terminal-count detect and clear, instantiated once and shared across sections via a mux of the latched count.

Test Plan:
- Counts 3/2/1, host valid every cycle:
  - 3 instr_load_en pulses with data 0xA0000001..3, then preload_en at addr 0,1, then preload_LS_en at addr 0.
  - RELEASE for 1 cycle, then core_rst=1.
  - Total 6 accepted beats.
- Counts 0/4/0 -> IMEM and LS skipped; preload_addr 0..3; no instr_load_en or preload_LS_en pulses ever.
- Counts 2/0/0 with in_valid toggling 1,0,0,1 -> exactly 2 strobes, each one cycle after its accepting edge; in_ready stays 1.
- rf_count=200 -> saturated to 128; last preload_addr=127; 128 beats accepted, then RELEASE.
- RUN for 10 cycles, then halt pulse -> DONE, run_cycles=11, core_rst=0; start in DONE restarts loading with run_cycles held until RELEASE.
- rst=0 asserted during L_RF at addr 5 -> next cycle IDLE, strobes 0, in_ready=0; start then reloads from IMEM addr 0.

Source files
------------

// File: rtl/spu_boot_pkg.sv
// Shared types and constants for the SPU boot sequencer.
package spu_boot_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int RF_DEPTH   = 128;
  localparam int LS_LINES   = 2048;
  localparam int LS_ADDR_W  = 11;
  localparam int RF_ADDR_W  = 7;
  localparam int INSTR_W    = 32;
  localparam int DATA_W     = 128;
  localparam int CNT_W      = LS_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    L_IMEM,
    L_RF,
    L_LS,
    RELEASE,
    RUN,
    DONE
  } state_t;

  // Clamp a requested section length to what the target can hold.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lim);
    return (c > lim) ? lim : c;
  endfunction

  // First section still to be loaded, in IMEM, RF, LS order; RELEASE if none.
  function automatic state_t first_section(input logic has_imem,
                                           input logic has_rf,
                                           input logic has_ls);
    if (has_imem) return L_IMEM;
    if (has_rf)   return L_RF;
    if (has_ls)   return L_LS;
    return RELEASE;
  endfunction

endpackage

// File: rtl/boot_section_counter.sv
// Beat index for the section currently being loaded, with terminal-count detect.
module boot_section_counter #(
  parameter int IDX_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           inc,
  input  logic [IDX_W:0] count,
  output logic [IDX_W-1:0] idx,
  output logic           last
);

  assign last = ({1'b0, idx} == (count - (IDX_W+1)'(1)));

  // Advance on each accepted beat; wrap to zero after the final beat of a section.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spu_boot_sequencer.sv
// Loads IMEM, RF and LS from a host stream, then runs the core until halt.
module spu_boot_sequencer
  import spu_boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [10:0]           imem_count,
  input  logic [7:0]            rf_count,
  input  logic [11:0]           ls_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:DATA_W-1]     in_data,
  input  logic                  halt,
  output logic                  instr_load_en,
  output logic [0:INSTR_W-1]    instr_load_data,
  output logic                  preload_en,
  output logic [RF_ADDR_W-1:0]  preload_addr,
  output logic [0:DATA_W-1]     preload_values,
  output logic                  preload_LS_en,
  output logic [LS_ADDR_W-1:0]  preload_LS_addr,
  output logic [0:DATA_W-1]     preload_LS_data,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           run_cycles
);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     imem_cnt;
  logic [CNT_W-1:0]     rf_cnt;
  logic [CNT_W-1:0]     ls_cnt;
  logic [CNT_W-1:0]     imem_sat;
  logic [CNT_W-1:0]     rf_sat;
  logic [CNT_W-1:0]     ls_sat;
  logic [CNT_W-1:0]     sec_count;
  logic [LS_ADDR_W-1:0] idx;
  logic                 idx_last;
  logic                 loading;
  logic                 accept;
  logic                 start_ok;

  assign imem_sat = sat_count(CNT_W'(imem_count), CNT_W'(IMEM_DEPTH));
  assign rf_sat   = sat_count(CNT_W'(rf_count),   CNT_W'(RF_DEPTH));
  assign ls_sat   = sat_count(ls_count,           CNT_W'(LS_LINES));
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    loading   = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    core_rst  = 1'b0;
    sec_count = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = first_section(imem_sat != '0, rf_sat != '0, ls_sat != '0);
      end
      L_IMEM: begin
        loading   = 1'b1;
        in_ready  = 1'b1;
        busy      = 1'b1;
        sec_count = imem_cnt;
        if (accept && idx_last) state_nxt = first_section(1'b0, rf_cnt != '0, ls_cnt != '0);
      end
      L_RF: begin
        loading   = 1'b1;
        in_ready  = 1'b1;
        busy      = 1'b1;
        sec_count = rf_cnt;
        if (accept && idx_last) state_nxt = first_section(1'b0, 1'b0, ls_cnt != '0);
      end
      L_LS: begin
        loading   = 1'b1;
        in_ready  = 1'b1;
        busy      = 1'b1;
        sec_count = ls_cnt;
        if (accept && idx_last) state_nxt = RELEASE;
      end
      RELEASE: begin
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        core_rst = 1'b1;
        if (halt) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = first_section(imem_sat != '0, rf_sat != '0, ls_sat != '0);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the saturated section lengths when a load begins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_cnt <= '0;
      rf_cnt   <= '0;
      ls_cnt   <= '0;
    end else if (start_ok) begin
      imem_cnt <= imem_sat;
      rf_cnt   <= rf_sat;
      ls_cnt   <= ls_sat;
    end
  end

  boot_section_counter #(
    .IDX_W(LS_ADDR_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(!loading),
    .inc  (accept),
    .count(sec_count),
    .idx  (idx),
    .last (idx_last)
  );

  // Register each accepted beat onto its section's preload port as a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_load_en   <= 1'b0;
      instr_load_data <= '0;
      preload_en      <= 1'b0;
      preload_addr    <= '0;
      preload_values  <= '0;
      preload_LS_en   <= 1'b0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
    end else begin
      instr_load_en <= accept && (state == L_IMEM);
      preload_en    <= accept && (state == L_RF);
      preload_LS_en <= accept && (state == L_LS);
      if (accept && (state == L_IMEM)) begin
        instr_load_data <= in_data[0:INSTR_W-1];
      end
      if (accept && (state == L_RF)) begin
        preload_addr   <= idx[RF_ADDR_W-1:0];
        preload_values <= in_data;
      end
      if (accept && (state == L_LS)) begin
        preload_LS_addr <= idx;
        preload_LS_data <= in_data;
      end
    end
  end

  // Run-cycle counter: cleared entering RELEASE, saturating count while in RUN, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cycles <= '0;
    end else if (state_nxt == RELEASE) begin
      run_cycles <= '0;
    end else if ((state == RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end

endmodule
